// File: rtl/unidade_mul_div_if.sv
// unidade_mul_div_if
// Groups the dispatch bus from the mul/div reservation station and the CDB
// request/grant handshake of the iterative multiply/divide unit.
//   dadoPronto, operation, operandoA, operandoB, nameIn : dispatch from station
//   ocupado, erroPerda                                 : status back to station
//   cdbRequest, resultado, nameOut / cdbGrant          : CDB handshake
// Modports:
//   master - station/arbiter side (drives dispatch and grant)
//   slave  - functional unit side
interface unidade_mul_div_if #(
  parameter int WIDTH = 16
);
  logic             dadoPronto;
  logic             operation;
  logic [WIDTH-1:0] operandoA;
  logic [WIDTH-1:0] operandoB;
  logic [2:0]       nameIn;
  logic             cdbGrant;
  logic             ocupado;
  logic             cdbRequest;
  logic [WIDTH-1:0] resultado;
  logic [2:0]       nameOut;
  logic             erroPerda;

  modport master (
    output dadoPronto, operation, operandoA, operandoB, nameIn, cdbGrant,
    input  ocupado, cdbRequest, resultado, nameOut, erroPerda
  );

  modport slave (
    input  dadoPronto, operation, operandoA, operandoB, nameIn, cdbGrant,
    output ocupado, cdbRequest, resultado, nameOut, erroPerda
  );
endinterface

// File: rtl/unidade_mul_div.sv
// unidade_mul_div
// Iterative unsigned multiply/divide unit sitting behind the mul/div
// reservation station. One operation is accepted on a dadoPronto strobe,
// computed over WIDTH cycles (shift-add multiply, LSB first; restoring
// divide, MSB first) and then offered on the CDB until granted.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high; clears all state
//   bus   - unidade_mul_div_if.slave (dispatch, status and CDB handshake)
module unidade_mul_div #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  unidade_mul_div_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cont;
  logic             op_r;       // 0 = multiply, 1 = divide
  logic [2:0]       tag_r;
  // acc   : multiply accumulator / divide partial remainder
  // reg_a : multiplicand (shifted left) / dividend shifting into quotient
  // reg_b : multiplier (shifted right) / divisor (constant)
  logic [WIDTH-1:0] acc, reg_a, reg_b;
  logic [WIDTH-1:0] acc_nx, reg_a_nx, reg_b_nx;
  logic [WIDTH-1:0] resultado_r;
  logic [2:0]       name_r;
  logic             erro_r;

  logic             ocupado;
  logic             accept;
  logic             div_zero;
  logic             last_it;

  // One shift-add step: add the multiplicand when the current multiplier
  // bit is set. Carries out of the top bit are dropped (truncated product).
  function automatic logic [WIDTH-1:0] mul_step(
    input logic [WIDTH-1:0] acc_in,
    input logic [WIDTH-1:0] mcand,
    input logic             mplier_bit
  );
    return mplier_bit ? (acc_in + mcand) : acc_in;
  endfunction

  // One restoring-division step. Returns {quotient_bit, new_remainder}.
  // The partial remainder is always below the divisor, so it fits WIDTH bits.
  function automatic logic [WIDTH:0] div_step(
    input logic [WIDTH-1:0] rem_in,
    input logic             next_bit,
    input logic [WIDTH-1:0] divisor
  );
    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;
    partial = {rem_in, next_bit};
    diff    = partial - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      return {1'b1, diff[WIDTH-1:0]};
    end
    return {1'b0, partial[WIDTH-1:0]};
  endfunction

  assign ocupado  = (state == CALC) || ((state == DONE) && !bus.cdbGrant);
  assign accept   = bus.dadoPronto && !ocupado;
  assign div_zero = bus.operation && (bus.operandoB == '0);
  assign last_it  = (cont == LAST_IT);

  assign bus.ocupado    = ocupado;
  assign bus.cdbRequest = (state == DONE);
  assign bus.resultado  = resultado_r;
  assign bus.nameOut    = name_r;
  assign bus.erroPerda  = erro_r;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. A dispatch on the grant edge in DONE is taken directly,
  // giving back-to-back operation with no idle cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = div_zero ? DONE : CALC;
      end
      CALC: begin
        if (last_it) state_nx = DONE;
      end
      DONE: begin
        if (bus.cdbGrant) begin
          if (accept) state_nx = div_zero ? DONE : CALC;
          else        state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Iteration datapath
  always_comb begin
    logic [WIDTH:0] dstep;
    acc_nx   = acc;
    reg_a_nx = reg_a;
    reg_b_nx = reg_b;
    dstep    = '0;
    if (op_r) begin
      dstep    = div_step(acc, reg_a[WIDTH-1], reg_b);
      acc_nx   = dstep[WIDTH-1:0];
      reg_a_nx = {reg_a[WIDTH-2:0], dstep[WIDTH]};
    end else begin
      acc_nx   = mul_step(acc, reg_a, reg_b[0]);
      reg_a_nx = {reg_a[WIDTH-2:0], 1'b0};
      reg_b_nx = {1'b0, reg_b[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont        <= '0;
      op_r        <= 1'b0;
      tag_r       <= '0;
      acc         <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      resultado_r <= '0;
      name_r      <= '0;
      erro_r      <= 1'b0;
    end else begin
      if (bus.dadoPronto && ocupado) begin
        erro_r <= 1'b1;
      end
      if (accept) begin
        op_r  <= bus.operation;
        tag_r <= bus.nameIn;
        cont  <= '0;
        acc   <= '0;
        reg_a <= bus.operandoA;
        reg_b <= bus.operandoB;
        // Divide by zero skips the iterations and reports all ones.
        if (div_zero) begin
          resultado_r <= '1;
          name_r      <= bus.nameIn;
        end
      end else if (state == CALC) begin
        cont  <= cont + 1'b1;
        acc   <= acc_nx;
        reg_a <= reg_a_nx;
        reg_b <= reg_b_nx;
        if (last_it) begin
          resultado_r <= op_r ? reg_a_nx : acc_nx;
          name_r      <= tag_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_unidade_mul_div.sv
module tb_unidade_mul_div;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  unidade_mul_div_if #(.WIDTH(16)) bus ();

  unidade_mul_div #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives a one-cycle dispatch strobe; returns #1 after the dispatch edge.
  task automatic dispatch(input logic op, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] tag);
    bus.dadoPronto = 1'b1;
    bus.operation  = op;
    bus.operandoA  = a;
    bus.operandoB  = b;
    bus.nameIn     = tag;
    step();
    bus.dadoPronto = 1'b0;
    bus.operandoA  = 16'hDEAD;
    bus.operandoB  = 16'hBEEF;
    bus.nameIn     = 3'b111;
  endtask

  // Counts edges until cdbRequest is seen (bounded at 40).
  task automatic wait_req(output int n);
    n = 0;
    while (!bus.cdbRequest && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.dadoPronto = 1'b0;
    bus.operation  = 1'b0;
    bus.operandoA  = '0;
    bus.operandoB  = '0;
    bus.nameIn     = '0;
    bus.cdbGrant   = 1'b0;
    step();
    step();
    checks++;
    if ({bus.cdbRequest, bus.ocupado, bus.erroPerda, bus.resultado, bus.nameOut} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b ocu=%b err=%b res=%h name=%b, want all 0",
               bus.cdbRequest, bus.ocupado, bus.erroPerda, bus.resultado, bus.nameOut);
    end
    reset = 1'b0;
    step();
  endtask

  // Runs one operation with grant tied high and checks latency, value, tag
  // and that the request is a single-cycle pulse.
  task automatic run_one(input string name, input logic op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] tag,
                         input int lat, input logic [15:0] exp_res);
    int n;
    bus.cdbGrant = 1'b1;
    dispatch(op, a, b, tag);
    wait_req(n);
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, want %0d", name, n, lat);
    end
    checks++;
    if (bus.resultado !== exp_res || bus.nameOut !== tag) begin
      errors++;
      $display("FAIL %s_result: got %h/%b, want %h/%b", name, bus.resultado, bus.nameOut, exp_res, tag);
    end
    step();
    checks++;
    if (bus.cdbRequest !== 1'b0 || bus.ocupado !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: got req=%b ocu=%b after grant, want 0/0", name, bus.cdbRequest, bus.ocupado);
    end
  endtask

  task automatic test_multiply();
    int n;
    bus.cdbGrant = 1'b1;
    dispatch(1'b0, 16'd7, 16'd9, 3'b100);
    checks++;
    if (bus.ocupado !== 1'b1 || bus.cdbRequest !== 1'b0) begin
      errors++;
      $display("FAIL mul_calc_status: got ocu=%b req=%b, want 1/0", bus.ocupado, bus.cdbRequest);
    end
    wait_req(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL mul_latency: got %0d edges, want 16", n);
    end
    checks++;
    if (bus.resultado !== 16'd63 || bus.nameOut !== 3'b100) begin
      errors++;
      $display("FAIL mul_result: got %0d/%b, want 63/100", bus.resultado, bus.nameOut);
    end
    step();
    checks++;
    if (bus.cdbRequest !== 1'b0) begin
      errors++;
      $display("FAIL mul_pulse: got req=%b, want 0", bus.cdbRequest);
    end
    checks++;
    if (bus.resultado !== 16'd63) begin
      errors++;
      $display("FAIL mul_hold_after: got %0d, want 63", bus.resultado);
    end
  endtask

  task automatic test_mul_overflow();
    run_one("mul_ovf", 1'b0, 16'd300, 16'd300, 3'b100, 16, 16'h5F90);
    run_one("mul_ffff", 1'b0, 16'hFFFF, 16'd1, 3'b101, 16, 16'hFFFF);
  endtask

  task automatic test_divide();
    run_one("div_100_7", 1'b1, 16'd100, 16'd7, 3'b101, 16, 16'd14);
    run_one("div_5_9", 1'b1, 16'd5, 16'd9, 3'b110, 16, 16'd0);
    run_one("div_ffff_1", 1'b1, 16'hFFFF, 16'd1, 3'b100, 16, 16'hFFFF);
    run_one("div_zero", 1'b1, 16'd42, 16'd0, 3'b110, 0, 16'hFFFF);
  endtask

  task automatic test_back_to_back();
    int n;
    bus.cdbGrant = 1'b0;
    dispatch(1'b0, 16'd8, 16'd5, 3'b100);
    wait_req(n);
    checks++;
    if (n !== 16 || bus.resultado !== 16'd40 || bus.nameOut !== 3'b100) begin
      errors++;
      $display("FAIL stall_first: got %0d edges %0d/%b, want 16 40/100", n, bus.resultado, bus.nameOut);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.cdbRequest !== 1'b1 || bus.ocupado !== 1'b1 ||
          bus.resultado !== 16'd40 || bus.nameOut !== 3'b100) begin
        errors++;
        $display("FAIL stall_hold%0d: got req=%b ocu=%b %0d/%b, want 1 1 40/100",
                 i, bus.cdbRequest, bus.ocupado, bus.resultado, bus.nameOut);
      end
    end
    bus.cdbGrant = 1'b1;
    #1;
    checks++;
    if (bus.ocupado !== 1'b0) begin
      errors++;
      $display("FAIL grant_frees: got ocu=%b with grant in DONE, want 0", bus.ocupado);
    end
    dispatch(1'b0, 16'd6, 16'd6, 3'b110);
    checks++;
    if (bus.cdbRequest !== 1'b0 || bus.ocupado !== 1'b1) begin
      errors++;
      $display("FAIL b2b_capture: got req=%b ocu=%b, want 0/1", bus.cdbRequest, bus.ocupado);
    end
    wait_req(n);
    checks++;
    if (n !== 16 || bus.resultado !== 16'd36 || bus.nameOut !== 3'b110) begin
      errors++;
      $display("FAIL b2b_result: got %0d edges %0d/%b, want 16 36/110", n, bus.resultado, bus.nameOut);
    end
    step();
  endtask

  task automatic test_lost_dispatch();
    int n;
    bus.cdbGrant = 1'b1;
    checks++;
    if (bus.erroPerda !== 1'b0) begin
      errors++;
      $display("FAIL erro_initial: got %b, want 0", bus.erroPerda);
    end
    dispatch(1'b0, 16'd7, 16'd9, 3'b100);
    step();
    step();
    dispatch(1'b0, 16'd2, 16'd2, 3'b101);
    checks++;
    if (bus.erroPerda !== 1'b1) begin
      errors++;
      $display("FAIL erro_set: got %b, want 1", bus.erroPerda);
    end
    wait_req(n);
    checks++;
    if (n !== 13 || bus.resultado !== 16'd63 || bus.nameOut !== 3'b100) begin
      errors++;
      $display("FAIL erro_first_intact: got %0d edges %0d/%b, want 13 63/100", n, bus.resultado, bus.nameOut);
    end
    step();
    step();
    checks++;
    if (bus.erroPerda !== 1'b1 || bus.cdbRequest !== 1'b0) begin
      errors++;
      $display("FAIL erro_sticky: got err=%b req=%b, want 1/0", bus.erroPerda, bus.cdbRequest);
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen = 0;
    int n;
    bus.cdbGrant = 1'b1;
    dispatch(1'b1, 16'd100, 16'd7, 3'b101);
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.cdbRequest, bus.ocupado, bus.erroPerda, bus.resultado, bus.nameOut} !== 22'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got req=%b ocu=%b err=%b res=%h name=%b, want all 0",
               bus.cdbRequest, bus.ocupado, bus.erroPerda, bus.resultado, bus.nameOut);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.cdbRequest) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_request: got %0d request cycles, want 0", seen);
    end
    dispatch(1'b1, 16'd6, 16'd2, 3'b110);
    wait_req(n);
    checks++;
    if (n !== 16 || bus.resultado !== 16'd3 || bus.nameOut !== 3'b110) begin
      errors++;
      $display("FAIL midreset_recover: got %0d edges %0d/%b, want 16 3/110", n, bus.resultado, bus.nameOut);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_mul_overflow();
    test_divide();
    test_back_to_back();
    test_lost_dispatch();
    test_reset_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
